// File: rtl/bus_pkg.sv
// Shared definitions for the bus terminal: field widths, packet field
// accessors and the saturating event counter type.
package bus_pkg;

    localparam int ID_W      = 8;
    localparam int PKT_MAX_W = 64;

    typedef logic [ID_W-1:0] sat_cnt_t;

    // Packets are zero-extended to PKT_MAX_W so one accessor serves every pckg_sz.
    function automatic logic [ID_W-1:0] pkt_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int sz);
        return pkt[sz-1 -: ID_W];
    endfunction

    function automatic logic [PKT_MAX_W-1:0] pkt_payload(input logic [PKT_MAX_W-1:0] pkt,
                                                         input int sz);
        logic [PKT_MAX_W-1:0] mask;
        mask = {PKT_MAX_W{1'b1}} >> (PKT_MAX_W - sz + ID_W);
        return pkt & mask;
    endfunction

    function automatic sat_cnt_t sat_inc(input sat_cnt_t c);
        return (c == {ID_W{1'b1}}) ? c : c + ID_W'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with zero-on-empty output; a write while full
// is still taken when a read happens on the same edge.
module sync_fifo #(
    parameter int width = 32,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             rd,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic             rd_en_s, wr_en_s;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_en_s = rd && !empty;
    assign wr_en_s = wr && (!full || rd_en_s);
    assign rdata   = empty ? {width{1'b0}} : mem_q[rptr_q[AW-1:0]];

    // Next-state for pointers and storage.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (wr_en_s) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d = wptr_q + (AW+1)'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_en_s) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage has no reset; stale words are never visible because of the empty mask.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bus_terminal_fifo.sv
// Device-side bus endpoint: TX queue toward the bus, address-filtered RX
// queue toward the host, plus drop/filter counters and an underflow flag.
module bus_terminal_fifo
    import bus_pkg::*;
#(
    parameter int               pckg_sz   = 32,
    parameter int               depth     = 8,
    parameter logic [ID_W-1:0]  id        = 8'd0,
    parameter logic [ID_W-1:0]  broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_rd,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    output logic               tx_underflow,
    output logic [7:0]         rx_drop_cnt,
    output logic [7:0]         rx_filt_cnt
);

    logic            tx_empty_s, rx_empty_s, rx_full_s;
    logic [ID_W-1:0] dest_s;
    logic            addr_hit_s, rx_wr_s, drop_s, filt_s;
    logic            underflow_q, underflow_d;
    sat_cnt_t        drop_cnt_q, drop_cnt_d, filt_cnt_q, filt_cnt_d;

    sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .full  (tx_full),
        .empty (tx_empty_s)
    );

    sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr_s),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    assign pndng        = !tx_empty_s;
    assign rx_valid     = !rx_empty_s;
    assign tx_underflow = underflow_q;
    assign rx_drop_cnt  = drop_cnt_q;
    assign rx_filt_cnt  = filt_cnt_q;

    assign dest_s     = pkt_dest(PKT_MAX_W'(D_push), pckg_sz);
    assign addr_hit_s = (dest_s == id) || (dest_s == broadcast);
    assign rx_wr_s    = push && addr_hit_s;
    // A full RX queue still accepts when the host reads on the same edge.
    assign drop_s     = rx_wr_s && rx_full_s && !rx_rd;
    assign filt_s     = push && !addr_hit_s;

    // Sticky underflow flag and saturating event counters.
    always_comb begin
        underflow_d = underflow_q | (pop & tx_empty_s);
        if (drop_s) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
        if (filt_s) begin
            filt_cnt_d = sat_inc(filt_cnt_q);
        end else begin
            filt_cnt_d = filt_cnt_q;
        end
    end

    // Flag and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_q <= 1'b0;
            drop_cnt_q  <= 8'h00;
            filt_cnt_q  <= 8'h00;
        end else begin
            underflow_q <= underflow_d;
            drop_cnt_q  <= drop_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Scoreboard bench: a queue-based reference model tracks both directions and
// a negedge monitor compares every DUT output against it.
module tb_bus_terminal_fifo;

    localparam int         W     = 32;
    localparam int         DEPTH = 8;
    localparam logic [7:0] MYID  = 8'd3;
    localparam logic [7:0] BC    = 8'hFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tx_wr = 1'b0, pop = 1'b0, push = 1'b0, rx_rd = 1'b0;
    logic [W-1:0]  tx_data = '0, D_push = '0;
    logic          tx_full, pndng, rx_valid, tx_underflow;
    logic [W-1:0]  D_pop, rx_data;
    logic [7:0]    rx_drop_cnt, rx_filt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    int           m_drop = 0, m_filt = 0;
    bit           m_uflow = 1'b0;

    bus_terminal_fifo #(.pckg_sz(W), .depth(DEPTH), .id(MYID), .broadcast(BC)) dut (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
        .rx_rd(rx_rd), .rx_valid(rx_valid), .rx_data(rx_data), .tx_underflow(tx_underflow),
        .rx_drop_cnt(rx_drop_cnt), .rx_filt_cnt(rx_filt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: applies the sampled inputs of each edge to plain queues.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            txq.delete();
            rxq.delete();
            m_drop  = 0;
            m_filt  = 0;
            m_uflow = 1'b0;
        end else begin
            bit tx_do_pop, tx_room, rx_do_rd, rx_room;
            tx_do_pop = pop && (txq.size() > 0);
            tx_room   = (txq.size() < DEPTH) || tx_do_pop;
            if (pop && txq.size() == 0) m_uflow = 1'b1;
            if (tx_do_pop) void'(txq.pop_front());
            if (tx_wr && tx_room) txq.push_back(tx_data);

            rx_do_rd = rx_rd && (rxq.size() > 0);
            rx_room  = (rxq.size() < DEPTH) || rx_do_rd;
            if (rx_do_rd) void'(rxq.pop_front());
            if (push) begin
                if (D_push[W-1 -: 8] == MYID || D_push[W-1 -: 8] == BC) begin
                    if (rx_room) rxq.push_back(D_push);
                    else if (m_drop < 255) m_drop++;
                end else if (m_filt < 255) begin
                    m_filt++;
                end
            end
        end
    end

    // Monitor: DUT outputs presented mid-cycle against the model state.
    always @(negedge clk) begin
        chk("pndng",    {31'd0, pndng},    {31'd0, txq.size() > 0});
        chk("tx_full",  {31'd0, tx_full},  {31'd0, txq.size() == DEPTH});
        chk("D_pop",    D_pop,    (txq.size() > 0) ? txq[0] : '0);
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, rxq.size() > 0});
        chk("rx_data",  rx_data,  (rxq.size() > 0) ? rxq[0] : '0);
        chk("tx_underflow", {31'd0, tx_underflow}, {31'd0, m_uflow});
        chk("rx_drop_cnt", {24'd0, rx_drop_cnt}, m_drop);
        chk("rx_filt_cnt", {24'd0, rx_filt_cnt}, m_filt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        tick();

        // TX basic
        for (int i = 1; i <= 3; i++) begin
            tx_wr = 1'b1; tx_data = {8'h02, 24'(i)}; tick();
        end
        idle();
        chk("tx_basic_head", D_pop, {8'h02, 24'd1});
        for (int i = 0; i < 3; i++) begin pop = 1'b1; tick(); end
        idle(); tick();

        // TX full boundary, then a write with same-cycle pop
        for (int i = 0; i < DEPTH; i++) begin
            tx_wr = 1'b1; tx_data = {8'h02, 24'(16 + i)}; tick();
        end
        tx_wr = 1'b1; tx_data = {8'h02, 24'hBAD}; tick();
        tx_wr = 1'b1; pop = 1'b1; tx_data = {8'h02, 24'h999}; tick();
        chk("tx_full_after_bypass", {31'd0, tx_full}, 32'd1);
        idle();
        for (int i = 0; i < DEPTH - 1; i++) begin pop = 1'b1; tick(); end
        idle();
        chk("tx_last_is_ninth", D_pop, {8'h02, 24'h999});
        pop = 1'b1; tick(); idle(); tick();

        // RX filter
        push = 1'b1; D_push = {8'd3, 24'h11};   tick();
        push = 1'b1; D_push = {8'd5, 24'h22};   tick();
        push = 1'b1; D_push = {8'hFF, 24'h33};  tick();
        push = 1'b1; D_push = {8'd3, 24'h44};   tick();
        idle();
        chk("rx_filt_one", {24'd0, rx_filt_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) begin rx_rd = 1'b1; tick(); end
        idle(); tick();

        // RX overflow and drop-counter saturation
        for (int i = 0; i < DEPTH + 300; i++) begin
            push = 1'b1; D_push = {8'd3, 24'(i)}; tick();
        end
        idle();
        chk("rx_drop_sat", {24'd0, rx_drop_cnt}, 32'h0000_00FF);
        for (int i = 0; i < DEPTH; i++) begin rx_rd = 1'b1; tick(); end
        idle(); tick();

        // Underflow then asynchronous reset between edges
        pop = 1'b1; tick(); idle();
        chk("underflow_set", {31'd0, tx_underflow}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tx_wr = 1'b1; tx_data = {8'h07, 24'(i)}; tick();
        end
        idle();
        #2 reset = 1'b1;
        #1;
        chk("rst_pndng",   {31'd0, pndng},        32'd0);
        chk("rst_D_pop",   D_pop,                 32'd0);
        chk("rst_tx_full", {31'd0, tx_full},      32'd0);
        chk("rst_uflow",   {31'd0, tx_underflow}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid},    32'd0);
        chk("rst_rx_data", rx_data,               32'd0);
        chk("rst_drop",    {24'd0, rx_drop_cnt},  32'd0);
        chk("rst_filt",    {24'd0, rx_filt_cnt},  32'd0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("pndng_after_reset", {31'd0, pndng}, 32'd0);

        // Randomized traffic in both directions
        for (int i = 0; i < 2000; i++) begin
            int sel;
            tx_wr   = ($urandom_range(0, 99) < 55);
            tx_data = $urandom;
            pop     = ($urandom_range(0, 99) < 45);
            push    = ($urandom_range(0, 99) < 55);
            rx_rd   = ($urandom_range(0, 99) < 45);
            sel     = $urandom_range(0, 3);
            D_push  = $urandom;
            if (sel == 0) D_push[W-1 -: 8] = MYID;
            else if (sel == 1) D_push[W-1 -: 8] = BC;
            else if (sel == 2) D_push[W-1 -: 8] = 8'd3 + 8'(1 + $urandom_range(0, 200));
            tick();
        end
        idle(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
